// File: rtl/ramupload.sv
// HPS upload (readback) path for cart battery RAM over the ioctl port.
// Serves IOCTL_RD strobes from the RAM read port and raises save requests.
module ramupload #(
   parameter int ADDR_W  = 13,
   parameter int SIZE    = 8192,
   parameter int RAM_LAT = 1,
   parameter int MENUSUB = 2
) (
   input  logic              CLK_SYS,
   input  logic              RESB,
   input  logic              IOCTL_UPLOAD,
   input  logic [15:0]       IOCTL_INDEX,
   input  logic              IOCTL_RD,
   input  logic [26:0]       IOCTL_ADDR,
   output logic [7:0]        IOCTL_DIN,
   output logic              IOCTL_WAIT,
   output logic              IOCTL_UPLOAD_REQ,
   input  logic              SAVE_REQ,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic              RAM_EN,
   input  logic [7:0]        RAM_DATA,
   output logic              UPLOAD_ACTIVE,
   output logic              UPLOAD_DONE
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_FETCH = 2'd1;
   localparam logic [1:0]  S_DATA  = 2'd2;
   localparam logic [31:0] SIZE_C  = SIZE;
   localparam logic [1:0]  LAT_M1  = 2'(RAM_LAT - 1);
   localparam logic [5:0]  SUB     = 6'(MENUSUB);

   logic [1:0] state;
   logic [1:0] cnt;
   logic       sel;
   logic       sel_rise;
   logic       rd_sel;
   logic       in_range;
   logic       save_q;
   logic       save_edge;
   logic       pend;
   logic       req_n;
   logic       pend_n;
   logic       unused_idx;

   assign unused_idx = ^IOCTL_INDEX[15:6];

   assign sel       = IOCTL_UPLOAD & (IOCTL_INDEX[5:0] == SUB);
   assign sel_rise  = sel & ~UPLOAD_ACTIVE;
   assign rd_sel    = IOCTL_RD & sel;
   assign in_range  = {5'd0, IOCTL_ADDR} < SIZE_C;
   assign save_edge = SAVE_REQ & ~save_q;

   // The DATA cycle is the one where DIN is fresh, so it never stalls.
   assign IOCTL_WAIT = (state == S_FETCH) |
                       ((state == S_IDLE) & rd_sel);

   always_comb begin
      req_n  = IOCTL_UPLOAD_REQ;
      pend_n = pend;
      if (UPLOAD_DONE & pend) begin
         req_n  = 1'b1;
         pend_n = 1'b0;
      end
      // A session start consumes any request, even one arriving now.
      if (sel_rise) begin
         req_n  = 1'b0;
         pend_n = 1'b0;
      end else if (save_edge) begin
         if (sel) pend_n = 1'b1;
         else     req_n  = 1'b1;
      end
   end

   always_ff @(posedge CLK_SYS or negedge RESB) begin
      if (!RESB) begin
         state            <= S_IDLE;
         cnt              <= 2'd0;
         IOCTL_DIN        <= 8'h00;
         IOCTL_UPLOAD_REQ <= 1'b0;
         RAM_ADDR         <= '0;
         RAM_EN           <= 1'b0;
         UPLOAD_ACTIVE    <= 1'b0;
         UPLOAD_DONE      <= 1'b0;
         save_q           <= 1'b0;
         pend             <= 1'b0;
      end else begin
         UPLOAD_ACTIVE    <= sel;
         UPLOAD_DONE      <= UPLOAD_ACTIVE & ~sel;
         save_q           <= SAVE_REQ;
         IOCTL_UPLOAD_REQ <= req_n;
         pend             <= pend_n;
         case (state)
            S_IDLE: begin
               if (rd_sel) begin
                  if (in_range) begin
                     RAM_ADDR <= IOCTL_ADDR[ADDR_W-1:0];
                     RAM_EN   <= 1'b1;
                     cnt      <= LAT_M1;
                     state    <= S_FETCH;
                  end else begin
                     IOCTL_DIN <= 8'hFF;
                     state     <= S_DATA;
                  end
               end else if (IOCTL_RD) begin
                  IOCTL_DIN <= 8'h00;
               end
            end
            S_FETCH: begin
               RAM_EN <= 1'b0;
               if (!sel) begin
                  state <= S_IDLE;
               end else if (cnt == 2'd0) begin
                  IOCTL_DIN <= RAM_DATA;
                  state     <= S_DATA;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            S_DATA:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ramupload.sv
// Bench for ramupload: one instance at RAM latency 1, one at latency 3,
// fed the same ioctl stimulus and each backed by its own RAM model.
module tb_ramupload;

   logic        clk = 1'b0;
   logic        resb;
   logic        upload;
   logic        rd;
   logic        save;
   logic [15:0] index;
   logic [26:0] addr;

   logic [7:0]  din1, din3, rdata1, rdata3;
   logic        wait1, wait3, req1, req3;
   logic        ren1, ren3, act1, act3, done1, done3;
   logic [12:0] raddr1, raddr3;

   logic [7:0]  mem [0:8191];
   logic [7:0]  p1, p2;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [26:0] a;
      logic [15:0] idx;
      int          viol;
      int          w1;
      int          w3;
      logic [7:0]  din;
      int          en;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   ramupload #(.ADDR_W(13), .SIZE(8192), .RAM_LAT(1), .MENUSUB(2)) u_dut1 (
      .CLK_SYS(clk), .RESB(resb), .IOCTL_UPLOAD(upload),
      .IOCTL_INDEX(index), .IOCTL_RD(rd), .IOCTL_ADDR(addr),
      .IOCTL_DIN(din1), .IOCTL_WAIT(wait1), .IOCTL_UPLOAD_REQ(req1),
      .SAVE_REQ(save), .RAM_ADDR(raddr1), .RAM_EN(ren1),
      .RAM_DATA(rdata1), .UPLOAD_ACTIVE(act1), .UPLOAD_DONE(done1)
   );

   ramupload #(.ADDR_W(13), .SIZE(8192), .RAM_LAT(3), .MENUSUB(2)) u_dut3 (
      .CLK_SYS(clk), .RESB(resb), .IOCTL_UPLOAD(upload),
      .IOCTL_INDEX(index), .IOCTL_RD(rd), .IOCTL_ADDR(addr),
      .IOCTL_DIN(din3), .IOCTL_WAIT(wait3), .IOCTL_UPLOAD_REQ(req3),
      .SAVE_REQ(save), .RAM_ADDR(raddr3), .RAM_EN(ren3),
      .RAM_DATA(rdata3), .UPLOAD_ACTIVE(act3), .UPLOAD_DONE(done3)
   );

   // RAM models: address/enable registers are the DUT outputs; data is
   // garbage unless the enable was presented the right number of cycles ago.
   assign rdata1 = ren1 ? mem[raddr1] : 8'hEE;

   always @(posedge clk) begin
      p1 <= ren3 ? mem[raddr3] : 8'hEE;
      p2 <= p1;
   end
   assign rdata3 = p2;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: what one strobe should produce, from the protocol rules.
   function automatic void model(input logic [26:0] a, input logic [15:0] idx,
                                 input int lat, output int w,
                                 output logic [7:0] d, output int e);
      if (idx[5:0] != 6'd2) begin
         w = 0; d = 8'h00; e = 0;
      end else if (a < 27'd8192) begin
         w = lat + 1; d = mem[a[12:0]]; e = 1;
      end else begin
         w = 1; d = 8'hFF; e = 0;
      end
   endfunction

   task automatic tick(input logic up, input logic sv);
      @(negedge clk);
      upload = up;
      save   = sv;
      #1;
   endtask

   task automatic run_read(input string tag, input logic [26:0] a,
                           input logic [15:0] idx, input int viol,
                           input int ew1, input int ew3,
                           input logic [7:0] edin, input int een);
      int w1, w3, e1, e3;
      logic st1, st3, g1, g3;
      logic [7:0] d1, d3;
      logic [12:0] ra1, ra3;
      w1 = 0; w3 = 0; e1 = 0; e3 = 0;
      st1 = 1'b1; st3 = 1'b1; g1 = 1'b0; g3 = 1'b0;
      d1 = 8'h00; d3 = 8'h00; ra1 = '0; ra3 = '0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         index = idx;
         rd    = (c == 0) || (viol != 0 && c == viol);
         addr  = (c == 0) ? a : 27'd1;
         #1;
         if (st1) begin if (wait1) w1++; else st1 = 1'b0; end
         if (st3) begin if (wait3) w3++; else st3 = 1'b0; end
         if (c >= 1 && !g1 && !wait1) begin g1 = 1'b1; d1 = din1; end
         if (c >= 1 && !g3 && !wait3) begin g3 = 1'b1; d3 = din3; end
         if (ren1) begin e1++; ra1 = raddr1; end
         if (ren3) begin e3++; ra3 = raddr3; end
      end
      rd = 1'b0;
      chk({tag, "_wait1"}, 32'(w1), 32'(ew1));
      chk({tag, "_wait3"}, 32'(w3), 32'(ew3));
      chk({tag, "_din1"}, 32'(d1), 32'(edin));
      chk({tag, "_din3"}, 32'(d3), 32'(edin));
      chk({tag, "_en1"}, 32'(e1), 32'(een));
      chk({tag, "_en3"}, 32'(e3), 32'(een));
      if (een != 0) begin
         chk({tag, "_raddr1"}, 32'(ra1), 32'(a[12:0]));
         chk({tag, "_raddr3"}, 32'(ra3), 32'(a[12:0]));
      end
   endtask

   initial begin
      int dn1, dn3, w1, w3, e;
      logic [7:0] d;
      logic [26:0] a;
      logic [15:0] idx;
      int viol;

      resb = 1'b0; upload = 1'b0; rd = 1'b0; save = 1'b0;
      index = 16'd2; addr = '0;
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h5A; mem[1] = 8'hC3; mem[100] = 8'h77; mem[8191] = 8'hA5;

      tbl[0] = '{27'd0,         16'd2,      0, 2, 4, 8'h5A, 1};
      tbl[1] = '{27'd1,         16'd2,      0, 2, 4, 8'hC3, 1};
      tbl[2] = '{27'd8192,      16'd2,      0, 1, 1, 8'hFF, 0};
      tbl[3] = '{27'd1,         16'd1,      0, 0, 0, 8'h00, 0};
      tbl[4] = '{27'd100,       16'd2,      2, 2, 4, 8'h77, 1};
      tbl[5] = '{27'd8191,      16'd2,      1, 2, 4, 8'hA5, 1};
      tbl[6] = '{27'h4000064,   16'd2,      0, 1, 1, 8'hFF, 0};
      tbl[7] = '{27'd0,         16'hFFC2,   0, 2, 4, 8'h5A, 1};

      repeat (3) @(negedge clk);
      #1;
      chk("reset1", 32'({din1, wait1, req1, ren1, raddr1, act1, done1}), 32'd0);
      chk("reset3", 32'({din3, wait3, req3, ren3, raddr3, act3, done3}), 32'd0);
      @(negedge clk);
      resb = 1'b1;
      upload = 1'b1;

      for (int i = 0; i < 8; i++)
         run_read($sformatf("vec%0d", i), tbl[i].a, tbl[i].idx, tbl[i].viol,
                  tbl[i].w1, tbl[i].w3, tbl[i].din, tbl[i].en);

      // Abort: upload drops while the latency-3 fetch is in flight.
      index = 16'd2;
      tick(1'b1, 1'b0);
      @(negedge clk);
      rd = 1'b1; addr = 27'd1;
      #1;
      dn1 = 0; dn3 = 0;
      for (int c = 1; c < 7; c++) begin
         @(negedge clk);
         rd = 1'b0;
         if (c == 1) upload = 1'b0;
         #1;
         dn1 += int'(done1);
         dn3 += int'(done3);
         if (c == 2) begin
            chk("abort_wait", 32'({wait1, wait3}), 32'd0);
            chk("abort_act", 32'({act1, act3}), 32'd0);
         end
      end
      chk("abort_din1", 32'(din1), 32'h5A);
      chk("abort_din3", 32'(din3), 32'h5A);
      chk("abort_done1", 32'(dn1), 32'd1);
      chk("abort_done3", 32'(dn3), 32'd1);

      // Save request handshake.
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      chk("req_set", 32'({req1, req3}), 32'd3);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      chk("req_hold", 32'({req1, req3}), 32'd3);
      tick(1'b1, 1'b1);
      chk("req_at_rise", 32'({req1, req3}), 32'd3);
      tick(1'b1, 1'b1);
      chk("req_clr", 32'({req1, req3}), 32'd0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      chk("req_pend_quiet", 32'({req1, req3}), 32'd0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      chk("req_at_done", 32'({req1, req3, done1, done3}), 32'b0011);
      tick(1'b0, 1'b1);
      chk("req_reraise", 32'({req1, req3}), 32'd3);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      chk("req_simul_clr", 32'({req1, req3}), 32'd0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      chk("req_simul_nopend", 32'({req1, req3}), 32'd0);
      tick(1'b0, 1'b1);
      chk("req_simul_nopend2", 32'({req1, req3}), 32'd0);

      // Reset while fetching, with a save edge pending from mid-session.
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      @(negedge clk);
      rd = 1'b1; addr = 27'd100;
      #1;
      @(negedge clk);
      rd = 1'b0;
      #1;
      chk("fetch_busy", 32'({wait3, ren3}), 32'd3);
      #1 resb = 1'b0;
      #1;
      chk("rst_async1", 32'({din1, wait1, req1, ren1, raddr1, act1, done1}), 32'd0);
      chk("rst_async3", 32'({din3, wait3, req3, ren3, raddr3, act3, done3}), 32'd0);
      @(negedge clk);
      resb = 1'b1;
      run_read("post_rst", 27'd0, 16'd2, 0, 2, 4, 8'h5A, 1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      chk("rst_pend_lost", 32'({req1, req3}), 32'd0);

      // Randomized reads against the reference model.
      tick(1'b1, 1'b0);
      for (int n = 0; n < 60; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 7)      a = 27'($urandom_range(0, 8191));
         else if (r < 9) a = 27'(8192 + $urandom_range(0, 200));
         else            a = 27'($urandom);
         idx = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'd2;
         model(a, idx, 1, w1, d, e);
         model(a, idx, 3, w3, d, e);
         viol = (e != 0) ? int'($urandom_range(0, 2)) : 0;
         run_read($sformatf("rnd%0d", n), a, idx, viol, w1, w3, d, e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
